// File: rtl/button_arbiter_pkg.sv
// Shared constants for the button arbiter slice.
// Key id encodings match the game-control FSM.
package button_arbiter_pkg;

    localparam int NUM_BTN_DEF = 4;
    localparam int IDW_DEF     = 2;
    localparam int DEPTH_DEF   = 4;

    typedef enum logic [1:0] {
        KEY_RED = 2'd0,
        KEY_GRN = 2'd1,
        KEY_BLU = 2'd2,
        KEY_YEL = 2'd3
    } key_e;

    // Round-robin successor of idx among n requesters
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous key FIFO with flush.
// Head value reads as zero while empty.
module key_fifo
    import button_arbiter_pkg::*;
#(
    parameter int W     = IDW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push && rst && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/button_arbiter.sv
// Round-robin arbiter from button pulses into a key FIFO.
// en=0 flushes queued and pending keys but keeps rr_ptr.
module button_arbiter
    import button_arbiter_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEF,
    parameter int IDW     = IDW_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NUM_BTN-1:0]     pulse_in,
    input  logic                   key_ack,
    input  logic                   ovf_clr,
    output logic                   key_valid,
    output logic [IDW-1:0]         key_id,
    output logic [NUM_BTN-1:0]     pending,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    logic [IDW-1:0]     rr_ptr;
    logic               grant_vld;
    logic [IDW-1:0]     grant_idx;
    logic [NUM_BTN-1:0] grant_oh;
    logic               fifo_full;
    logic               fifo_empty;
    logic               can_grant;
    logic               merge;
    logic               pop;

    assign can_grant = en && !fifo_full;
    assign pop       = key_ack && key_valid;
    assign key_valid = !fifo_empty;
    assign merge     = en && (|(pulse_in & pending & ~grant_oh));

    // Search pending from rr_ptr upward, first set bit wins
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_BTN;
            if (!grant_vld && can_grant && pending[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
        if (grant_vld) grant_oh = NUM_BTN'(1) << grant_idx;
    end

    // Latch requests; a same-cycle grant lets a new pulse re-arm
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
        end else if (!en) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant_oh) | pulse_in;
        end
    end

    // Advance the round-robin pointer past each granted index
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= IDW'(rr_next(int'(grant_idx), NUM_BTN));
        end
    end

    // Sticky overflow; a merge beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (merge) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    key_fifo #(
        .W     (IDW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!en),
        .push  (grant_vld),
        .din   (grant_idx),
        .pop   (pop),
        .dout  (key_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_button_arbiter.sv
// Directed testbench for button_arbiter.
// Each task drives one scenario and checks inline.
module tb_button_arbiter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] pulse_in;
    logic       key_ack;
    logic       ovf_clr;
    logic       key_valid;
    logic [1:0] key_id;
    logic [3:0] pending;
    logic [2:0] fifo_count;
    logic       overflow;

    int tests_run;
    int tests_failed;

    button_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pulse_in   (pulse_in),
        .key_ack    (key_ack),
        .ovf_clr    (ovf_clr),
        .key_valid  (key_valid),
        .key_id     (key_id),
        .pending    (pending),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b1; pulse_in = '0; key_ack = 0; ovf_clr = 0;
        do_reset();
        tests_run++;
        if (key_valid !== 1'b0 || key_id !== 2'd0 || pending !== 4'b0
            || fifo_count !== 3'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: v=%b id=%0d p=%b c=%0d o=%b",
                     key_valid, key_id, pending, fifo_count, overflow);
        end
    endtask

    task automatic test_single();
        do_reset();
        pulse_in = 4'b0100;
        tick();
        pulse_in = '0;
        tests_run++;
        if (pending !== 4'b0100 || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_latch: p=%b v=%b want 0100 0",
                     pending, key_valid);
        end
        tick();
        tests_run++;
        if (key_valid !== 1'b1 || key_id !== 2'd2 || fifo_count !== 3'd1
            || pending !== 4'b0) begin
            tests_failed++;
            $display("FAIL single_grant: v=%b id=%0d c=%0d p=%b want 1 2 1 0000",
                     key_valid, key_id, fifo_count, pending);
        end
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        tests_run++;
        if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL single_pop: v=%b c=%0d want 0 0",
                     key_valid, fifo_count);
        end
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        tests_run++;
        if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL ack_when_empty: v=%b c=%0d want 0 0",
                     key_valid, fifo_count);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_seq [5];
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd3;
        exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
        do_reset();
        pulse_in = 4'b1011;
        tick();
        pulse_in = '0;
        tick();
        tests_run++;
        if (key_id !== 2'd0 || fifo_count !== 3'd1 || pending !== 4'b1010) begin
            tests_failed++;
            $display("FAIL rr_first: id=%0d c=%0d p=%b want 0 1 1010",
                     key_id, fifo_count, pending);
        end
        tick();
        tick();
        tests_run++;
        if (fifo_count !== 3'd3 || pending !== 4'b0) begin
            tests_failed++;
            $display("FAIL rr_three: c=%0d p=%b want 3 0000",
                     fifo_count, pending);
        end
        pulse_in = 4'b0011;
        tick();
        pulse_in = '0;
        tick();
        tick();
        tests_run++;
        if (fifo_count !== 3'd4 || pending !== 4'b0010) begin
            tests_failed++;
            $display("FAIL rr_wrap_full: c=%0d p=%b want 4 0010",
                     fifo_count, pending);
        end
        for (int j = 0; j < 5; j++) begin
            tests_run++;
            if (key_valid !== 1'b1 || key_id !== exp_seq[j]) begin
                tests_failed++;
                $display("FAIL rr_pop%0d: v=%b id=%0d want 1 %0d",
                         j, key_valid, key_id, exp_seq[j]);
            end
            key_ack = 1'b1;
            tick();
            key_ack = 1'b0;
            tick();
        end
        tests_run++;
        if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL rr_drained: v=%b c=%0d want 0 0",
                     key_valid, fifo_count);
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        pulse_in = 4'b0001; tick();
        pulse_in = 4'b0010; tick();
        pulse_in = 4'b0100; tick();
        pulse_in = 4'b1000; tick();
        pulse_in = '0;      tick();
        tests_run++;
        if (fifo_count !== 3'd4 || pending !== 4'b0) begin
            tests_failed++;
            $display("FAIL full_fill: c=%0d p=%b want 4 0000",
                     fifo_count, pending);
        end
        pulse_in = 4'b0100;
        tick();
        pulse_in = '0;
        tick();
        tests_run++;
        if (pending !== 4'b0100 || fifo_count !== 3'd4 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_stall: p=%b c=%0d o=%b want 0100 4 0",
                     pending, fifo_count, overflow);
        end
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd3 || pending !== 4'b0100 || key_id !== 2'd1) begin
            tests_failed++;
            $display("FAIL full_pop: c=%0d p=%b id=%0d want 3 0100 1",
                     fifo_count, pending, key_id);
        end
        tick();
        tests_run++;
        if (fifo_count !== 3'd4 || pending !== 4'b0) begin
            tests_failed++;
            $display("FAIL full_refill: c=%0d p=%b want 4 0000",
                     fifo_count, pending);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'd2; exp_seq[1] = 2'd3;
        exp_seq[2] = 2'd2; exp_seq[3] = 2'd1;
        pulse_in = 4'b0010; tick();
        pulse_in = 4'b0010; tick();
        pulse_in = '0;
        tests_run++;
        if (overflow !== 1'b1 || pending !== 4'b0010 || fifo_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL ovf_merge: o=%b p=%b c=%0d want 1 0010 4",
                     overflow, pending, fifo_count);
        end
        pulse_in = 4'b0010;
        ovf_clr  = 1'b1;
        tick();
        pulse_in = '0;
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set_wins: o=%b want 1", overflow);
        end
        tick();
        ovf_clr = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: o=%b want 0", overflow);
        end
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        tick();
        tests_run++;
        if (pending !== 4'b0 || fifo_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL ovf_single_key: p=%b c=%0d want 0000 4",
                     pending, fifo_count);
        end
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (key_valid !== 1'b1 || key_id !== exp_seq[j]) begin
                tests_failed++;
                $display("FAIL ovf_pop%0d: v=%b id=%0d want 1 %0d",
                         j, key_valid, key_id, exp_seq[j]);
            end
            key_ack = 1'b1;
            tick();
            key_ack = 1'b0;
        end
        tests_run++;
        if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL ovf_drained: v=%b c=%0d want 0 0",
                     key_valid, fifo_count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        pulse_in = 4'b0111; tick();
        pulse_in = '0;      tick();
        pulse_in = 4'b1000; tick();
        pulse_in = '0;      tick();
        tests_run++;
        if (fifo_count !== 3'd3 || pending !== 4'b1000) begin
            tests_failed++;
            $display("FAIL flush_setup: c=%0d p=%b want 3 1000",
                     fifo_count, pending);
        end
        en = 1'b0;
        tick();
        tests_run++;
        if (fifo_count !== 3'd0 || key_valid !== 1'b0 || pending !== 4'b0
            || key_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL flush_clear: c=%0d v=%b p=%b id=%0d want 0 0 0000 0",
                     fifo_count, key_valid, pending, key_id);
        end
        pulse_in = 4'b1111;
        tick();
        pulse_in = '0;
        tick();
        tests_run++;
        if (pending !== 4'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_ignore: p=%b c=%0d o=%b want 0000 0 0",
                     pending, fifo_count, overflow);
        end
        en = 1'b1;
        tick();
        tests_run++;
        if (pending !== 4'b0 || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_reenable: p=%b v=%b want 0000 0",
                     pending, key_valid);
        end
    endtask

    task automatic test_reset_mid();
        pulse_in = 4'b0001; tick();
        pulse_in = 4'b0001; tick();
        pulse_in = '0;
        tests_run++;
        if (key_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_setup: v=%b want 1", key_valid);
        end
        rst     = 1'b0;
        key_ack = 1'b1;
        tick();
        rst     = 1'b1;
        key_ack = 1'b0;
        tests_run++;
        if (key_valid !== 1'b0 || key_id !== 2'd0 || pending !== 4'b0
            || fifo_count !== 3'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: v=%b id=%0d p=%b c=%0d o=%b want zeros",
                     key_valid, key_id, pending, fifo_count, overflow);
        end
        pulse_in = 4'b1000;
        tick();
        pulse_in = '0;
        tick();
        tests_run++;
        if (key_valid !== 1'b1 || key_id !== 2'd3 || fifo_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL mid_after: v=%b id=%0d c=%0d want 1 3 1",
                     key_valid, key_id, fifo_count);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b0;
        en       = 1'b1;
        pulse_in = '0;
        key_ack  = 1'b0;
        ovf_clr  = 1'b0;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_overflow();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/button_arbiter.md
Name: button_arbiter

Overview:
- Collects single-cycle button pulses from the per-button shapers.
- Arbitrates them round-robin and queues the resulting key codes in a small FIFO.
- Presents the key codes one at a time to the game-control FSM over a valid/ack handshake.
- Gated by the game phase: keys are accepted only while the player's input phase is active.

Parameters:
- NUM_BTN, 4, number of button pulse inputs (2..8)
- IDW, 2, key id width; must satisfy 2**IDW >= NUM_BTN
- DEPTH, 4, key FIFO depth (power of two, >= 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- en  in  1  accept enable (player input phase); 0 flushes the block
- pulse_in  in  NUM_BTN  one-cycle-high shaped button pulses, bit i = button i
- key_ack  in  1  consumer pops head key; honoured only when key_valid=1
- ovf_clr  in  1  clears the overflow flag
- key_valid  out  1  FIFO non-empty
- key_id  out  IDW  button index at FIFO head; 0 when empty
- pending  out  NUM_BTN  latched, not-yet-granted requests
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a request was merged or lost

Behaviour:
- Reset (rst=0 at a clk edge): pending=0, FIFO emptied, fifo_count=0, key_valid=0, key_id=0, overflow=0, rr_ptr=0. Reset overrides every other input, including mid-handshake.
- en=0 at an edge:
  - pending, FIFO and count are cleared; pulses that cycle are ignored; rr_ptr is held.
  - overflow is held unless ovf_clr=1.
- Request latch (en=1):
  - pulse_in[i]=1 sets pending[i].
  - If pending[i] is already 1 and i is not granted this cycle, the pulse merges and overflow is set.
  - If i is granted in the same cycle, pending[i] stays 1 (new request) and overflow is not set.
- Arbiter, combinational on the registered pending and rr_ptr:
  - Searches indices rr_ptr, rr_ptr+1, … mod NUM_BTN; grants the first set bit.
  - Grant is allowed only when fifo_count < DEPTH; at most one grant per cycle.
  - On grant to i: write i into the FIFO, clear pending[i], rr_ptr <= (i+1) mod NUM_BTN.
  - With no grant, rr_ptr is unchanged.
- FIFO:
  - Pop occurs when key_ack=1 and key_valid=1; key_ack while empty is ignored.
  - Push and pop in the same cycle leave fifo_count unchanged, and the ordering is preserved.
  - When full, grants stall and requests stay pending; pending requests are never dropped while full.
  - Read and write pointers wrap mod DEPTH.
- Latency:
  - A pulse sampled at edge k sets pending after k.
  - If the FIFO is empty and no higher-priority request is pending, it is written at edge k+1, so key_valid=1 and key_id=i after edge k+1.
- Overflow:
  - Sets on a merged pulse.
  - ovf_clr=1 clears it; if a set event and ovf_clr coincide, set wins.
- All outputs are registered or driven directly from registers (key_id from the FIFO head register/array); there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package/header holds: default NUM_BTN/IDW/DEPTH constants and key id encodings, e.g. KEY_RED=0, KEY_GRN=1, KEY_BLU=2, KEY_YEL=3, matching the game FSM.
- Sub-module key_fifo: a synchronous FIFO with push/pop/full/empty/count, parameterised by width IDW and depth DEPTH, reset synchronous active-low.
- The round-robin arbiter stays inline in button_arbiter.

Test Plan:
- Single press: reset, en=1, pulse_in=4'b0100 for 1 cycle → key_valid=1, key_id=2 two edges after the pulse; key_ack=1 for 1 cycle → key_valid=0, fifo_count=0.
- Simultaneous press with round-robin: pulse_in=4'b1011 in one cycle, no ack → FIFO fills in order 0,1,3 on successive edges, rr_ptr=0 after the last grant. Then pulse_in=4'b0011 → grant order 0,1 (pointer wrapped). Pop sequence yields 0,1,3,0,1.
- Full stall: DEPTH=4, fill with 4 keys, then pulse button 2 → pending=4'b0100, fifo_count=4, no loss. One key_ack → next edge writes key 2, pending=0, fifo_count stays 4.
- Overflow: pulse button 1 twice while the FIFO is full → overflow=1, pending[1]=1, a single key 1 is eventually queued. ovf_clr=1 → overflow=0.
- Gating and flush: with 3 keys queued and pending=4'b1000, drop en to 0 for 1 cycle → fifo_count=0, key_valid=0, pending=0. Pulses while en=0 → no effect.
- Reset mid-handshake: key_valid=1, key_ack=1 coincident with rst=0 → all outputs 0 next edge. Release rst and pulse button 3 → key_id=3, and button 3 is granted first because rr_ptr=0 after reset and no lower index is pending.
